// File: rtl/gf2_pkg.sv
// Shared helpers for the GF(2) RREF solver: bit utilities and the FSM state type.
// GF2_RREF_SOLVE_MINW_EN adds the ENUM state used by the minimum-weight search.
package gf2_pkg;

  localparam int GF2_MAXW = 32;

`ifdef GF2_RREF_SOLVE_MINW_EN
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_ENUM} gf2_solve_state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_SCAN} gf2_solve_state_e;
`endif

  function automatic logic [5:0] popcount(input logic [GF2_MAXW-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < GF2_MAXW; i++) c = c + {5'd0, v[i]};
    return c;
  endfunction

  // Scatter the low bits of src, in order, onto the set bits of mask.
  function automatic logic [GF2_MAXW-1:0] pdep(input logic [GF2_MAXW-1:0] src,
                                               input logic [GF2_MAXW-1:0] mask);
    logic [GF2_MAXW-1:0] res;
    int j;
    res = '0;
    j = 0;
    for (int i = 0; i < GF2_MAXW; i++) begin
      if (mask[i]) begin
        res[i] = src[j];
        j++;
      end
    end
    return res;
  endfunction

  function automatic logic [4:0] lowest_set(input logic [GF2_MAXW-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = GF2_MAXW - 1; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/gf2_rref_solve_eval.sv
// Combinational candidate evaluator: free-variable assignment k plus the
// pivot rows give a full solution vector and its Hamming weight.
module gf2_rref_solve_eval
  import gf2_pkg::*;
#(
  parameter int ROWS = 2,
  parameter int COLS = 3,
  parameter int IW   = 1
) (
  input  logic [COLS-1:0]         i_mat [ROWS-1:0],
  input  logic [ROWS-1:0]         i_piv_vld,
  input  logic [IW-1:0]           i_piv_idx [ROWS-1:0],
  input  logic [COLS-2:0]         i_free,
  input  logic [COLS-2:0]         i_k,
  output logic [COLS-2:0]         o_cand,
  output logic [$clog2(COLS)-1:0] o_cand_w
);

  localparam int NV = COLS - 1;
  localparam int WW = $clog2(COLS);

  logic [NV-1:0] w_assign;
  logic [NV-1:0] w_x;

  always_comb begin
    w_assign = NV'(pdep(GF2_MAXW'(i_k), GF2_MAXW'(i_free)));
    w_x      = w_assign;
    // Pivot bits are never free, so the row's own pivot contributes nothing to the parity.
    for (int r = 0; r < ROWS; r++) begin
      if (i_piv_vld[r] && (int'(i_piv_idx[r]) < NV))
        w_x[i_piv_idx[r]] = i_mat[r][NV] ^ (^(i_mat[r][NV-1:0] & w_assign));
    end
  end

  assign o_cand   = w_x;
  assign o_cand_w = WW'(popcount(GF2_MAXW'(w_x)));

endmodule

// File: rtl/gf2_rref_solve.sv
// Extracts a solution (minimum-weight when GF2_RREF_SOLVE_MINW_EN is defined,
// otherwise the free-vars-zero particular solution) from a GF(2) RREF matrix.
module gf2_rref_solve
  import gf2_pkg::*;
#(
  parameter int ROWS = 2,
  parameter int COLS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [COLS-1:0]         RREF [ROWS-1:0],
  output logic                    ready,
  output logic                    solvable,
  output logic [COLS-2:0]         solution,
  output logic [$clog2(COLS)-1:0] min_weight
);

  localparam int NV = COLS - 1;
  localparam int WW = $clog2(COLS);
  localparam int IW = (NV > 1) ? $clog2(NV) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int KW = NV + 1;

  gf2_solve_state_e r_state;
  logic [COLS-1:0]  r_mat [ROWS-1:0];
  logic [RW-1:0]    r_row;
  logic [NV-1:0]    r_pmask;
  logic             r_incons;
  logic [ROWS-1:0]  r_piv_vld;
  logic [IW-1:0]    r_piv_idx [ROWS-1:0];
  logic             r_ready;
  logic             r_solvable;
  logic [NV-1:0]    r_solution;
  logic [WW-1:0]    r_min_w;

  logic [COLS-1:0]  w_cur_row;
  logic [NV-1:0]    w_cur_vars;
  logic             w_cur_has;
  logic [IW-1:0]    w_cur_idx;
  logic             w_scan;
  logic             w_last_row;
  logic             w_incons_n;
  logic [ROWS-1:0]  w_piv_vld_n;
  logic [IW-1:0]    w_piv_idx_n [ROWS-1:0];
  logic [NV-1:0]    w_pmask_n;
  logic [NV-1:0]    w_free;
  logic [NV-1:0]    w_k_eval;
  logic [NV-1:0]    w_cand;
  logic [WW-1:0]    w_cand_w;

  assign w_cur_row  = r_mat[r_row];
  assign w_cur_vars = w_cur_row[NV-1:0];
  assign w_cur_has  = |w_cur_vars;
  assign w_cur_idx  = IW'(lowest_set(GF2_MAXW'(w_cur_vars)));
  assign w_scan     = (r_state == S_SCAN);
  assign w_last_row = (r_row == RW'(ROWS - 1));
  assign w_incons_n = r_incons | (w_scan & ~w_cur_has & w_cur_row[NV]);

  // Pivot view including the row being scanned, so the last SCAN cycle sees the final pivots.
  always_comb begin
    w_piv_vld_n = r_piv_vld;
    w_piv_idx_n = r_piv_idx;
    w_pmask_n   = r_pmask;
    if (w_scan && w_cur_has) begin
      w_piv_vld_n[r_row] = 1'b1;
      w_piv_idx_n[r_row] = w_cur_idx;
      w_pmask_n[w_cur_idx] = 1'b1;
    end
  end

  assign w_free = ~w_pmask_n;

`ifdef GF2_RREF_SOLVE_MINW_EN
  logic [KW-1:0] r_k;
  logic [WW-1:0] r_best_w;
  logic [NV-1:0] r_best_sol;
  logic [5:0]    w_nfree;
  logic [KW-1:0] w_last_k;
  logic          w_better;

  assign w_nfree  = popcount(GF2_MAXW'(w_free));
  assign w_last_k = (KW'(1) << w_nfree) - KW'(1);
  // k==0 always seeds the best, so an all-ones weight never blocks the first candidate.
  assign w_better = (r_k == '0) || (w_cand_w < r_best_w);
  assign w_k_eval = r_k[NV-1:0];
`else
  assign w_k_eval = '0;
`endif

  gf2_rref_solve_eval #(
    .ROWS (ROWS),
    .COLS (COLS),
    .IW   (IW)
  ) u_eval (
    .i_mat     (r_mat),
    .i_piv_vld (w_piv_vld_n),
    .i_piv_idx (w_piv_idx_n),
    .i_free    (w_free),
    .i_k       (w_k_eval),
    .o_cand    (w_cand),
    .o_cand_w  (w_cand_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_row      <= '0;
      r_pmask    <= '0;
      r_incons   <= 1'b0;
      r_piv_vld  <= '0;
      r_ready    <= 1'b1;
      r_solvable <= 1'b0;
      r_solution <= '0;
      r_min_w    <= '0;
`ifdef GF2_RREF_SOLVE_MINW_EN
      r_k        <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mat      <= RREF;
            r_row      <= '0;
            r_pmask    <= '0;
            r_incons   <= 1'b0;
            r_piv_vld  <= '0;
            r_ready    <= 1'b0;
            r_state    <= S_SCAN;
`ifdef GF2_RREF_SOLVE_MINW_EN
            r_k        <= '0;
            r_best_w   <= '1;
            r_best_sol <= '0;
`endif
          end
        end
        S_SCAN: begin
          r_piv_vld <= w_piv_vld_n;
          r_piv_idx <= w_piv_idx_n;
          r_pmask   <= w_pmask_n;
          r_incons  <= w_incons_n;
          r_row     <= r_row + RW'(1);
          if (w_last_row) begin
            if (w_incons_n) begin
              r_state    <= S_IDLE;
              r_ready    <= 1'b1;
              r_solvable <= 1'b0;
              r_solution <= '0;
              r_min_w    <= '0;
            end else begin
`ifdef GF2_RREF_SOLVE_MINW_EN
              r_state    <= S_ENUM;
`else
              r_state    <= S_IDLE;
              r_ready    <= 1'b1;
              r_solvable <= 1'b1;
              r_solution <= w_cand;
              r_min_w    <= w_cand_w;
`endif
            end
          end
        end
`ifdef GF2_RREF_SOLVE_MINW_EN
        S_ENUM: begin
          if (w_better) begin
            r_best_w   <= w_cand_w;
            r_best_sol <= w_cand;
          end
          r_k <= r_k + KW'(1);
          if (r_k == w_last_k) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b1;
            r_solvable <= 1'b1;
            r_solution <= w_better ? w_cand : r_best_sol;
            r_min_w    <= w_better ? w_cand_w : r_best_w;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready      = r_ready;
  assign solvable   = r_solvable;
  assign solution   = r_solution;
  assign min_weight = r_min_w;

endmodule
